// File: rtl/game_mode_pkg.sv
// Shared types and helpers for the tank-game mode controller.
package game_mode_pkg;

  typedef enum logic [2:0] {
    MODE_START = 3'd0,
    MODE_PLAY1 = 3'd1,
    MODE_PLAY2 = 3'd2,
    MODE_OVER  = 3'd3
  } mode_t;

  localparam logic SEL_ONE = 1'b1;
  localparam logic SEL_TWO = 1'b0;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic logic is_play(input mode_t m);
    return (m == MODE_PLAY1) || (m == MODE_PLAY2);
  endfunction

  function automatic mode_t play_mode(input logic sel);
    return (sel == SEL_ONE) ? MODE_PLAY1 : MODE_PLAY2;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchroniser, counter debouncer and registered press pulse.
// A button already held when reset releases stays masked until it is seen released.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned FILL_W = 2;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(2);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [1:0]        sync_q;
  logic              deb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FILL_W-1:0] fill_q;
  logic              armed_q;
  logic              press_q;

  logic sync_c;
  logic differ_c;
  logic toggle_c;
  logic rise_c;

  assign sync_c   = sync_q[1];
  assign differ_c = (sync_c != deb_q);
  assign toggle_c = differ_c && (cnt_q == CNT_MAX);
  assign rise_c   = toggle_c && !deb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};

      if (!differ_c) begin
        cnt_q <= '0;
      end else if (toggle_c) begin
        cnt_q <= '0;
        deb_q <= ~deb_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      // Arm only once the synchroniser has flushed and shows the button released.
      if (fill_q != FILL_DONE) begin
        fill_q <= fill_q + FILL_W'(1);
      end else if (!sync_c) begin
        armed_q <= 1'b1;
      end

      press_q <= rise_c && armed_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_mode_ctrl.sv
// Tank-game mode controller: button conditioning plus START/PLAY1/PLAY2/OVER state machine.
// Optional feature macro: GAME_MODE_AUTORET_EN (timed return from OVER to START).
module game_mode_ctrl
  import game_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter int unsigned AUTORET_CYCLES  = 125_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  input  logic       game_over_in,
  output logic [2:0] mode,
  output logic       btn_mode_sel,
  output logic       game_rst,
  output logic       mode_change
);

  if (AUTORET_CYCLES < 2) begin : g_bad_autoret
    $error("game_mode_ctrl: AUTORET_CYCLES must be at least 2");
  end

  logic up_p;
  logic dn_p;
  logic en_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (up_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .press (dn_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_enter),
    .press (en_p)
  );

  mode_t mode_q, mode_d;
  logic  sel_q, sel_d;
  logic  game_rst_q, game_rst_d;
  logic  mode_change_q, mode_change_d;
  logic  autoret_hit_c;

`ifdef GAME_MODE_AUTORET_EN
  localparam int unsigned AR_W = $clog2(AUTORET_CYCLES);
  localparam logic [AR_W-1:0] AR_LAST = AR_W'(AUTORET_CYCLES - 1);

  logic [AR_W-1:0] ar_cnt_q;
  logic [AR_W-1:0] ar_cnt_d;

  // Counter runs only while OVER persists; any entry or exit restarts it at zero.
  assign autoret_hit_c = (mode_q == MODE_OVER) && (ar_cnt_q == AR_LAST);
  assign ar_cnt_d      = ((mode_q == MODE_OVER) && (mode_d == MODE_OVER)) ?
                         ar_cnt_q + AR_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_cnt_q <= '0;
    end else begin
      ar_cnt_q <= ar_cnt_d;
    end
  end
`else
  assign autoret_hit_c = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    mode_d        = mode_q;
    sel_d         = sel_q;
    mode_change_d = 1'b0;
    game_rst_d    = 1'b0;

    case (mode_q)
      MODE_START: begin
        if (en_p) begin
          mode_d = play_mode(sel_q);
        end else if (up_p != dn_p) begin
          sel_d = up_p ? SEL_ONE : SEL_TWO;
        end
      end
      MODE_PLAY1, MODE_PLAY2: begin
        if (game_over_in) begin
          mode_d = MODE_OVER;
        end
      end
      MODE_OVER: begin
        if (en_p || autoret_hit_c) begin
          mode_d = MODE_START;
          sel_d  = SEL_ONE;
        end
      end
      default: begin
        mode_d = MODE_START;
        sel_d  = SEL_ONE;
      end
    endcase

    mode_change_d = (mode_d != mode_q);
    game_rst_d    = mode_change_d && is_play(mode_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= MODE_START;
      sel_q         <= SEL_ONE;
      game_rst_q    <= 1'b0;
      mode_change_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      sel_q         <= sel_d;
      game_rst_q    <= game_rst_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign mode         = mode_q;
  assign btn_mode_sel = sel_q;
  assign game_rst     = game_rst_q;
  assign mode_change  = mode_change_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Self-checking bench for game_mode_ctrl: vector table, timing sequences and a random run
// against an event-level model of the mode rules.
module tb_game_mode_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned AR  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_enter;
  logic       game_over_in;
  logic [2:0] mode;
  logic       btn_mode_sel;
  logic       game_rst;
  logic       mode_change;

  always #5 clk = ~clk;

  game_mode_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .AUTORET_CYCLES  (AR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_enter    (btn_enter),
    .game_over_in (game_over_in),
    .mode         (mode),
    .btn_mode_sel (btn_mode_sel),
    .game_rst     (game_rst),
    .mode_change  (mode_change)
  );

  int checks   = 0;
  int failures = 0;
  int mc_cnt   = 0;
  int gr_cnt   = 0;

  // Pulse counters sampled well after each active edge.
  always @(posedge clk) begin
    #2;
    mc_cnt += int'(mode_change);
    gr_cnt += int'(game_rst);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic u, input logic d, input logic e);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_enter = e;
    repeat (8) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic go_pulse();
    @(negedge clk);
    game_over_in = 1'b1;
    @(negedge clk);
    game_over_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Event-level reference model of the mode rules.
  int   m_mode;
  logic m_sel;
  int   m_mc;
  int   m_gr;

  task automatic model_press(input logic u, input logic d, input logic e);
    if (m_mode == 0) begin
      if (e) begin
        m_mode = m_sel ? 1 : 2;
        m_mc++;
        m_gr++;
      end else if (u != d) begin
        m_sel = u;
      end
    end else if (m_mode == 3 && e) begin
      m_mode = 0;
      m_sel  = 1'b1;
      m_mc++;
    end
  endtask

  typedef struct {
    logic up;
    logic dn;
    logic en;
    logic go;
    int   exp_mode;
    logic exp_sel;
    int   exp_mc;
    int   exp_gr;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  int found;
  int mc_at, gr_at, mc_after, gr_after;
  int mc_base, gr_base;
  int r, combo;
  logic u, d, e;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1, 0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 1, 1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1, 0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1, 0};

    rst = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0; game_over_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state and quiet idle.
    check("rst_mode", int'(mode), 0);
    check("rst_sel", int'(btn_mode_sel), 1);
    check("rst_game_rst", int'(game_rst), 0);
    check("rst_mode_change", int'(mode_change), 0);
    repeat (100) @(negedge clk);
    check("idle_mode", int'(mode), 0);
    check("idle_mc_pulses", mc_cnt, 0);
    check("idle_gr_pulses", gr_cnt, 0);

    // Short glitch is filtered.
    @(negedge clk);
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    btn_down = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_sel", int'(btn_mode_sel), 1);
    check("glitch_mc", mc_cnt, 0);

    // Raw edge to cursor move latency.
    @(negedge clk);
    btn_down = 1'b1;
    found = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (found < 0 && btn_mode_sel == 1'b0) found = k;
    end
    btn_down = 1'b0;
    repeat (12) @(negedge clk);
    check("dn_latency", found, 7);
    check("dn_sel", int'(btn_mode_sel), 0);

    // Enter into PLAY2 with single-cycle pulses.
    mc_base = mc_cnt; gr_base = gr_cnt;
    @(negedge clk);
    btn_enter = 1'b1;
    found = -1; mc_at = -1; gr_at = -1; mc_after = -1; gr_after = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (found < 0 && mode == 3'd2) begin
        found = k; mc_at = int'(mode_change); gr_at = int'(game_rst);
      end else if (found > 0 && k == found + 1) begin
        mc_after = int'(mode_change); gr_after = int'(game_rst);
      end
    end
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    check("en_latency", found, 7);
    check("en_mode", int'(mode), 2);
    check("en_mc_first", mc_at, 1);
    check("en_gr_first", gr_at, 1);
    check("en_mc_next", mc_after, 0);
    check("en_gr_next", gr_after, 0);
    check("en_mc_total", mc_cnt - mc_base, 1);
    check("en_gr_total", gr_cnt - gr_base, 1);

    // Through OVER and back, then game-over latency from PLAY1.
    go_pulse();
    check("p2_over", int'(mode), 3);
    press(1'b0, 1'b0, 1'b1);
    check("over_start", int'(mode), 0);
    check("over_sel", int'(btn_mode_sel), 1);
    press(1'b0, 1'b0, 1'b1);
    check("play1", int'(mode), 1);
    press(1'b0, 1'b0, 1'b1);
    check("play1_en_ignored", int'(mode), 1);
    @(negedge clk);
    game_over_in = 1'b1;
    @(posedge clk); #1;
    check("go_latency", int'(mode), 3);
    @(negedge clk);
    game_over_in = 1'b0;
    press(1'b0, 1'b0, 1'b1);
    check("over_en_mode", int'(mode), 0);
    check("over_en_sel", int'(btn_mode_sel), 1);

    // Vector table.
    for (int i = 0; i < NVEC; i++) begin
      mc_base = mc_cnt; gr_base = gr_cnt;
      if (tbl[i].go) go_pulse();
      else press(tbl[i].up, tbl[i].dn, tbl[i].en);
      check($sformatf("tbl%0d_mode", i), int'(mode), tbl[i].exp_mode);
      check($sformatf("tbl%0d_sel", i), int'(btn_mode_sel), int'(tbl[i].exp_sel));
      check($sformatf("tbl%0d_mc", i), mc_cnt - mc_base, tbl[i].exp_mc);
      check($sformatf("tbl%0d_gr", i), gr_cnt - gr_base, tbl[i].exp_gr);
    end

    // Reset mid-PLAY2 with Enter held.
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    check("rst_seq_play2", int'(mode), 2);
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (10) @(negedge clk);
    mc_base = mc_cnt; gr_base = gr_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_mode", int'(mode), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_held_mode", int'(mode), 0);
    check("rst_held_mc", mc_cnt - mc_base, 0);
    check("rst_held_gr", gr_cnt - gr_base, 0);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_release_mode", int'(mode), 0);
    mc_base = mc_cnt; gr_base = gr_cnt;
    press(1'b0, 1'b0, 1'b1);
    check("rst_repress_mode", int'(mode), 1);
    check("rst_repress_gr", gr_cnt - gr_base, 1);

`ifdef GAME_MODE_AUTORET_EN
    // Timed return from OVER.
    @(negedge clk);
    game_over_in = 1'b1;
    @(posedge clk); #1;
    game_over_in = 1'b0;
    check("ar_enter_over", int'(mode), 3);
    found = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (found < 0 && mode == 3'd0) found = k;
    end
    check("ar_return_cycle", found, 20);
    check("ar_return_sel", int'(btn_mode_sel), 1);

    // Enter beats the timer.
    press(1'b0, 1'b0, 1'b1);
    check("ar_play1", int'(mode), 1);
    mc_base = mc_cnt;
    @(negedge clk);
    game_over_in = 1'b1;
    @(posedge clk); #1;
    game_over_in = 1'b0;
    found = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 3) btn_enter = 1'b1;
      if (k == 13) btn_enter = 1'b0;
      if (found < 0 && mode == 3'd0) found = k;
    end
    repeat (12) @(negedge clk);
    check("ar_en_cycle", found, 10);
    check("ar_en_mode", int'(mode), 0);
    check("ar_en_mc", mc_cnt - mc_base, 2);
`endif

    // Random run against the model.
    do_reset();
    m_mode = 0; m_sel = 1'b1; m_mc = 0; m_gr = 0;
    mc_base = mc_cnt; gr_base = gr_cnt;
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        go_pulse();
        if (m_mode == 1 || m_mode == 2) begin
          m_mode = 3;
          m_mc++;
`ifdef GAME_MODE_AUTORET_EN
          repeat (25) @(negedge clk);
          m_mode = 0;
          m_sel  = 1'b1;
          m_mc++;
`endif
        end
      end else begin
        combo = int'($urandom_range(1, 7));
        u = (combo % 2) == 1;
        d = ((combo / 2) % 2) == 1;
        e = ((combo / 4) % 2) == 1;
        press(u, d, e);
        model_press(u, d, e);
      end
      check($sformatf("rnd%0d_mode", i), int'(mode), m_mode);
      check($sformatf("rnd%0d_sel", i), int'(btn_mode_sel), int'(m_sel));
    end
    check("rnd_mc_total", mc_cnt - mc_base, m_mc);
    check("rnd_gr_total", gr_cnt - gr_base, m_gr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
